tile_pick_ctrl: RTL and testbench
=================================

Name: tile_pick_ctrl

Overview:
- Downstream consumer of the mouse interface block; converts single-cycle left-click pulses plus block coordinates into a two-click "pick source tile, pick destination tile" move request for the game-logic block.
- Owns the selection state, the selection highlight coordinates fed to the display, a selection timeout, and a req/ack handshake toward game logic.
- Forwards the cheat gesture as a registered one-cycle request.

Parameters:
- COLS, 18, number of valid block columns; block_x >= COLS is treated as off-board.
- ROWS, 8, number of valid block rows; block_y >= ROWS is treated as off-board.
- TIMEOUT_CYC, 100_000_000, cycles a held source selection survives without a second click (1 s at 100 MHz).

Ports:
- clk  in  1  system clock; single clock domain, same as the mouse interface.
- rst  in  1  synchronous active-high reset.
- interboard_rst  in  1  synchronous active-high reset from the peer board; ORed with rst, identical effect.
- my_turn  in  1  level; high while this board may act.
- l_click  in  1  one-cycle left-click pulse.
- cheat_activate  in  1  one-cycle pulse.
- mouse_inblock  in  1  high when the pointer is over a tile block.
- mouse_block_x  in  5  column index of the pointer.
- mouse_block_y  in  3  row index of the pointer.
- move_ack  in  1  game logic has consumed the move; pulse or level.
- sel_valid  out  1  a source tile is held; drives the highlight.
- sel_x  out  5  held source column.
- sel_y  out  3  held source row.
- move_req  out  1  move request pending.
- dst_x  out  5  destination column; valid while move_req is high.
- dst_y  out  3  destination row; valid while move_req is high.
- cheat_req  out  1  one-cycle cheat pulse.

Behaviour:
- Definitions:
  - all_rst = rst | interboard_rst.
  - hit = l_click & mouse_inblock & (mouse_block_x < COLS) & (mouse_block_y < ROWS).
  - miss = l_click & ~hit.
- States: IDLE, HELD, REQ. Encode in 2 bits; unused encoding returns to IDLE.
- Reset (all_rst sampled high at a clock edge):
  - state = IDLE; all outputs 0; timeout counter = 0.
  - Applies mid-handshake as well: move_req drops on that same edge, and no ack is awaited afterwards.
- IDLE:
  - hit & my_turn: latch sel_x/sel_y from mouse_block_x/mouse_block_y, clear the counter, go to HELD. sel_valid is high the next cycle (latency 1).
  - Any other click, including a click while ~my_turn: ignored.
- HELD (sel_valid = 1). Conditions are checked in this priority order:
  1. ~my_turn: go to IDLE.
  2. hit on the same block as (sel_x, sel_y): deselect, go to IDLE.
  3. hit on a different block: latch dst_x/dst_y, go to REQ. move_req rises the next cycle.
  4. miss: cancel, go to IDLE.
  5. counter == TIMEOUT_CYC-1: go to IDLE.
  6. Otherwise: counter increments.
- Timeout counter:
  - Width is $clog2(TIMEOUT_CYC).
  - Runs only in HELD and never wraps; it is cleared on every entry to HELD.
- REQ:
  - move_req = 1; sel_valid stays 1.
  - sel_x, sel_y, dst_x and dst_y are held stable.
  - All clicks are ignored, and my_turn is ignored.
  - move_ack high: go to IDLE. move_req and sel_valid are 0 the next cycle.
  - An ack that is high in the same cycle move_req first rises is honoured, so minimum request width is 1 cycle.
  - move_ack outside REQ is ignored.
- Leaving HELD or REQ for IDLE clears sel_valid. sel_x/sel_y/dst_x/dst_y keep their last values (don't-care while invalid).
- cheat_req: registered copy of cheat_activate, one-cycle latency. Independent of state and my_turn. Forced to 0 by all_rst.
- Simultaneous l_click and cheat_activate: both are processed in the same cycle with no interaction.
- All outputs are registered; no combinational path from inputs to outputs.

Test Plan:
- Reset, then my_turn=1, hit at (3,2), then hit at (7,5) -> sel_valid=1, sel=(3,2) one cycle after the first click; move_req=1, dst=(7,5) one cycle after the second click. Assert move_ack for 1 cycle -> move_req=0 and sel_valid=0 the next cycle.
- Hit (4,1), then hit (4,1) again -> sel_valid returns to 0 and move_req is never asserted. Hit (4,1), then a click with mouse_inblock=0 -> same result.
- Run with TIMEOUT_CYC=16: hit (0,0), then no clicks -> sel_valid falls after exactly 16 cycles in HELD. Repeat with a second click on cycle 15 -> REQ is entered, no timeout.
- my_turn=0 with hit (2,2) -> no selection. In HELD, drop my_turn -> IDLE. In REQ, drop my_turn -> move_req holds until move_ack.
- Hit on mouse_block_x=18 (off-board) -> ignored in IDLE, cancels in HELD. While move_req=1, assert interboard_rst for 1 cycle -> move_req=0 on that edge; a later move_ack has no effect.
- cheat_activate pulse in each state, including in the same cycle as a hit -> cheat_req is a single-cycle pulse one cycle later, and the FSM transition happens unchanged.

Source files
------------

// File: rtl/tile_pick_ctrl.sv
// tile_pick_ctrl
//   Turns single-cycle left-click pulses plus block coordinates from the mouse
//   interface into a two-click move request for game logic: the first click
//   picks a source tile, the second picks a destination. The source is held
//   with a highlight and expires if no second click arrives in time. A move is
//   presented on move_req/dst_* until game logic acknowledges it.
//
// Parameters
//   COLS         number of valid block columns (block_x >= COLS is off-board)
//   ROWS         number of valid block rows    (block_y >= ROWS is off-board)
//   TIMEOUT_CYC  cycles a held source survives without a second click
//
// Ports
//   clk             system clock
//   rst             synchronous active-high reset
//   interboard_rst  synchronous active-high reset from the peer board
//   my_turn         level, high while this board may act
//   l_click         one-cycle left-click pulse
//   cheat_activate  one-cycle cheat gesture pulse
//   mouse_inblock   pointer is over a tile block
//   mouse_block_x   pointer column
//   mouse_block_y   pointer row
//   move_ack        game logic consumed the move (pulse or level)
//   sel_valid       a source tile is held (highlight enable)
//   sel_x, sel_y    held source tile
//   move_req        move request pending
//   dst_x, dst_y    destination tile, valid while move_req is high
//   cheat_req       registered one-cycle copy of cheat_activate
//
// All outputs are registered; nothing combinational reaches a port.

module tile_pick_ctrl #(
   parameter int unsigned COLS        = 18,
   parameter int unsigned ROWS        = 8,
   parameter int unsigned TIMEOUT_CYC = 100_000_000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       interboard_rst,
   input  logic       my_turn,
   input  logic       l_click,
   input  logic       cheat_activate,
   input  logic       mouse_inblock,
   input  logic [4:0] mouse_block_x,
   input  logic [2:0] mouse_block_y,
   input  logic       move_ack,
   output logic       sel_valid,
   output logic [4:0] sel_x,
   output logic [2:0] sel_y,
   output logic       move_req,
   output logic [4:0] dst_x,
   output logic [2:0] dst_y,
   output logic       cheat_req
);

   // Guard against a zero-width counter for degenerate timeouts.
   localparam int unsigned CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_HELD = 2'd1,
      ST_REQ  = 2'd2
   } state_t;

   state_t           state_r;
   state_t           state_nxt_s;
   logic [CNT_W-1:0] cnt_r;
   logic [CNT_W-1:0] cnt_nxt_s;
   logic [4:0]       sel_x_nxt_s;
   logic [2:0]       sel_y_nxt_s;
   logic [4:0]       dst_x_nxt_s;
   logic [2:0]       dst_y_nxt_s;

   logic all_rst_s;
   logic on_board_s;
   logic hit_s;
   logic miss_s;
   logic same_blk_s;
   logic timeout_s;

   assign all_rst_s  = rst | interboard_rst;
   // Widen coordinates so the bound compares are done at parameter width.
   assign on_board_s = ({27'd0, mouse_block_x} < COLS) & ({29'd0, mouse_block_y} < ROWS);
   assign hit_s      = l_click & mouse_inblock & on_board_s;
   assign miss_s     = l_click & ~hit_s;
   assign same_blk_s = (mouse_block_x == sel_x) & (mouse_block_y == sel_y);
   assign timeout_s  = (cnt_r == CNT_LAST);

   // Next-state, coordinate latching and timeout counter update.
   always_comb begin
      state_nxt_s = state_r;
      cnt_nxt_s   = cnt_r;
      sel_x_nxt_s = sel_x;
      sel_y_nxt_s = sel_y;
      dst_x_nxt_s = dst_x;
      dst_y_nxt_s = dst_y;
      case (state_r)
         ST_IDLE: begin
            if (hit_s && my_turn) begin
               sel_x_nxt_s = mouse_block_x;
               sel_y_nxt_s = mouse_block_y;
               cnt_nxt_s   = {CNT_W{1'b0}};
               state_nxt_s = ST_HELD;
            end else begin
               state_nxt_s = ST_IDLE;
            end
         end
         ST_HELD: begin
            // Priority: turn loss, deselect, destination pick, cancel, expiry.
            if (!my_turn) begin
               state_nxt_s = ST_IDLE;
            end else if (hit_s && same_blk_s) begin
               state_nxt_s = ST_IDLE;
            end else if (hit_s) begin
               dst_x_nxt_s = mouse_block_x;
               dst_y_nxt_s = mouse_block_y;
               state_nxt_s = ST_REQ;
            end else if (miss_s) begin
               state_nxt_s = ST_IDLE;
            end else if (timeout_s) begin
               state_nxt_s = ST_IDLE;
            end else begin
               cnt_nxt_s = cnt_r + CNT_W'(1);
            end
         end
         ST_REQ: begin
            // Clicks and my_turn are deliberately ignored until the ack.
            if (move_ack) begin
               state_nxt_s = ST_IDLE;
            end else begin
               state_nxt_s = ST_REQ;
            end
         end
         default: begin
            state_nxt_s = ST_IDLE;
         end
      endcase
   end

   // State, counter and output registers; outputs decode from next state so they are registered.
   always_ff @(posedge clk) begin
      if (all_rst_s) begin
         state_r   <= ST_IDLE;
         cnt_r     <= {CNT_W{1'b0}};
         sel_valid <= 1'b0;
         sel_x     <= 5'd0;
         sel_y     <= 3'd0;
         move_req  <= 1'b0;
         dst_x     <= 5'd0;
         dst_y     <= 3'd0;
         cheat_req <= 1'b0;
      end else begin
         state_r   <= state_nxt_s;
         cnt_r     <= cnt_nxt_s;
         sel_valid <= (state_nxt_s == ST_HELD) || (state_nxt_s == ST_REQ);
         sel_x     <= sel_x_nxt_s;
         sel_y     <= sel_y_nxt_s;
         move_req  <= (state_nxt_s == ST_REQ);
         dst_x     <= dst_x_nxt_s;
         dst_y     <= dst_y_nxt_s;
         cheat_req <= cheat_activate;
      end
   end

endmodule

// File: tb/tb_tile_pick_ctrl.sv
// Directed bench for tile_pick_ctrl with a short timeout so expiry is reachable.
module tb_tile_pick_ctrl;

   logic       clk;
   logic       rst;
   logic       interboard_rst;
   logic       my_turn;
   logic       l_click;
   logic       cheat_activate;
   logic       mouse_inblock;
   logic [4:0] mouse_block_x;
   logic [2:0] mouse_block_y;
   logic       move_ack;
   logic       sel_valid;
   logic [4:0] sel_x;
   logic [2:0] sel_y;
   logic       move_req;
   logic [4:0] dst_x;
   logic [2:0] dst_y;
   logic       cheat_req;

   int vectors;
   int miscompares;

   tile_pick_ctrl #(
      .COLS        (18),
      .ROWS        (8),
      .TIMEOUT_CYC (16)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .interboard_rst (interboard_rst),
      .my_turn        (my_turn),
      .l_click        (l_click),
      .cheat_activate (cheat_activate),
      .mouse_inblock  (mouse_inblock),
      .mouse_block_x  (mouse_block_x),
      .mouse_block_y  (mouse_block_y),
      .move_ack       (move_ack),
      .sel_valid      (sel_valid),
      .sel_x          (sel_x),
      .sel_y          (sel_y),
      .move_req       (move_req),
      .dst_x          (dst_x),
      .dst_y          (dst_y),
      .cheat_req      (cheat_req)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance one clock and settle just past the edge before sampling.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One click cycle at (x,y), optionally with a cheat pulse in the same cycle.
   task automatic click(input logic [4:0] x, input logic [2:0] y, input logic inb, input logic ch);
      l_click        = 1'b1;
      mouse_inblock  = inb;
      mouse_block_x  = x;
      mouse_block_y  = y;
      cheat_activate = ch;
      tick();
      l_click        = 1'b0;
      cheat_activate = 1'b0;
   endtask

   task automatic ack();
      move_ack = 1'b1;
      tick();
      move_ack = 1'b0;
   endtask

   initial begin
      vectors        = 0;
      miscompares    = 0;
      rst            = 1'b1;
      interboard_rst = 1'b0;
      my_turn        = 1'b0;
      l_click        = 1'b0;
      cheat_activate = 1'b0;
      mouse_inblock  = 1'b0;
      mouse_block_x  = 5'd0;
      mouse_block_y  = 3'd0;
      move_ack       = 1'b0;

      // Reset state
      tick();
      tick();
      rst = 1'b0;
      chk("rst_sel_valid", sel_valid, 1'b0);
      chk("rst_move_req",  move_req,  1'b0);
      chk("rst_cheat_req", cheat_req, 1'b0);
      chk("rst_sel_x",     sel_x,     5'd0);
      chk("rst_dst_x",     dst_x,     5'd0);

      // Basic two-click move and ack
      my_turn = 1'b1;
      click(5'd3, 3'd2, 1'b1, 1'b0);
      chk("pick_sel_valid", sel_valid, 1'b1);
      chk("pick_sel_x",     sel_x,     5'd3);
      chk("pick_sel_y",     sel_y,     3'd2);
      chk("pick_move_req",  move_req,  1'b0);
      click(5'd7, 3'd5, 1'b1, 1'b0);
      chk("dst_move_req",  move_req,  1'b1);
      chk("dst_x",         dst_x,     5'd7);
      chk("dst_y",         dst_y,     3'd5);
      chk("dst_sel_x",     sel_x,     5'd3);
      chk("dst_sel_valid", sel_valid, 1'b1);
      tick();
      chk("req_hold", move_req, 1'b1);
      ack();
      chk("ack_move_req",  move_req,  1'b0);
      chk("ack_sel_valid", sel_valid, 1'b0);

      // Same-block deselect and off-block cancel
      click(5'd4, 3'd1, 1'b1, 1'b0);
      chk("desel_pick", sel_valid, 1'b1);
      click(5'd4, 3'd1, 1'b1, 1'b0);
      chk("desel_sel_valid", sel_valid, 1'b0);
      chk("desel_move_req",  move_req,  1'b0);
      click(5'd4, 3'd1, 1'b1, 1'b0);
      click(5'd4, 3'd1, 1'b0, 1'b0);
      chk("miss_sel_valid", sel_valid, 1'b0);
      chk("miss_move_req",  move_req,  1'b0);

      // Timeout: 16 cycles in HELD, then released
      click(5'd0, 3'd0, 1'b1, 1'b0);
      chk("to_held_0", sel_valid, 1'b1);
      for (int i = 1; i < 16; i++) begin
         tick();
         chk("to_held_n", sel_valid, 1'b1);
      end
      tick();
      chk("to_expired", sel_valid, 1'b0);

      // Second click on the final HELD cycle wins over expiry
      click(5'd0, 3'd0, 1'b1, 1'b0);
      for (int i = 1; i < 16; i++) begin
         tick();
      end
      chk("to_last_held", sel_valid, 1'b1);
      click(5'd1, 3'd0, 1'b1, 1'b0);
      chk("to_last_move_req", move_req, 1'b1);
      chk("to_last_dst_x",    dst_x,    5'd1);
      ack();
      chk("to_last_ack", move_req, 1'b0);

      // my_turn handling
      my_turn = 1'b0;
      click(5'd2, 3'd2, 1'b1, 1'b0);
      chk("noturn_pick", sel_valid, 1'b0);
      my_turn = 1'b1;
      click(5'd2, 3'd2, 1'b1, 1'b0);
      chk("turn_pick", sel_valid, 1'b1);
      my_turn = 1'b0;
      tick();
      chk("held_turn_drop", sel_valid, 1'b0);
      my_turn = 1'b1;
      click(5'd2, 3'd2, 1'b1, 1'b0);
      click(5'd5, 3'd3, 1'b1, 1'b0);
      chk("req_entered", move_req, 1'b1);
      my_turn = 1'b0;
      tick();
      chk("req_turn_drop", move_req, 1'b1);
      click(5'd6, 3'd6, 1'b1, 1'b0);
      chk("req_click_ign_req", move_req, 1'b1);
      chk("req_click_ign_dx",  dst_x,    5'd5);
      chk("req_click_ign_dy",  dst_y,    3'd3);
      ack();
      chk("req_turn_ack", move_req, 1'b0);
      my_turn = 1'b1;

      // Off-board columns and board edges
      click(5'd18, 3'd0, 1'b1, 1'b0);
      chk("off_idle", sel_valid, 1'b0);
      click(5'd2, 3'd7, 1'b1, 1'b0);
      chk("edge_y_pick", sel_valid, 1'b1);
      chk("edge_y_val",  sel_y,     3'd7);
      click(5'd18, 3'd0, 1'b1, 1'b0);
      chk("off_held_cancel", sel_valid, 1'b0);
      chk("off_held_req",    move_req,  1'b0);
      click(5'd17, 3'd7, 1'b1, 1'b0);
      chk("edge_x_pick", sel_valid, 1'b1);
      chk("edge_x_val",  sel_x,     5'd17);
      click(5'd17, 3'd7, 1'b1, 1'b0);
      chk("edge_x_desel", sel_valid, 1'b0);

      // Peer reset mid-handshake; a late ack changes nothing
      click(5'd1, 3'd1, 1'b1, 1'b0);
      click(5'd2, 3'd2, 1'b1, 1'b0);
      chk("ibr_req_up", move_req, 1'b1);
      interboard_rst = 1'b1;
      tick();
      interboard_rst = 1'b0;
      chk("ibr_move_req",  move_req,  1'b0);
      chk("ibr_sel_valid", sel_valid, 1'b0);
      chk("ibr_dst_x",     dst_x,     5'd0);
      ack();
      chk("ibr_late_ack_req", move_req,  1'b0);
      chk("ibr_late_ack_sel", sel_valid, 1'b0);

      // Cheat pulses in each state, alongside clicks
      click(5'd3, 3'd3, 1'b1, 1'b1);
      chk("cheat_idle_pulse", cheat_req, 1'b1);
      chk("cheat_idle_sel",   sel_valid, 1'b1);
      tick();
      chk("cheat_idle_end", cheat_req, 1'b0);
      cheat_activate = 1'b1;
      tick();
      cheat_activate = 1'b0;
      chk("cheat_held_pulse", cheat_req, 1'b1);
      chk("cheat_held_sel",   sel_valid, 1'b1);
      tick();
      chk("cheat_held_end", cheat_req, 1'b0);
      click(5'd4, 3'd4, 1'b1, 1'b1);
      chk("cheat_hit_pulse", cheat_req, 1'b1);
      chk("cheat_hit_req",   move_req,  1'b1);
      chk("cheat_hit_dst",   dst_x,     5'd4);
      cheat_activate = 1'b1;
      tick();
      cheat_activate = 1'b0;
      chk("cheat_req_pulse", cheat_req, 1'b1);
      chk("cheat_req_hold",  move_req,  1'b1);
      ack();
      chk("cheat_req_end", cheat_req, 1'b0);
      chk("cheat_ack",     move_req,  1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
